// File: rtl/gamepad_pmod_serializer_if.sv
// ============================================================================
// gamepad_pmod_serializer_if
// Parallel snapshot inputs and serial Pmod outputs of the gamepad serializer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface gamepad_pmod_serializer_if #(
    parameter int NUM_PADS = 1
);
    localparam int BIT_WIDTH = 12 * NUM_PADS;

    logic                 start;
    logic [BIT_WIDTH-1:0] buttons;
    logic [NUM_PADS-1:0]  present;
    logic                 pmod_data;
    logic                 pmod_clk;
    logic                 pmod_latch;
    logic                 busy;
    logic                 done;

    modport master (
        output start, buttons, present,
        input  pmod_data, pmod_clk, pmod_latch, busy, done
    );

    modport slave (
        input  start, buttons, present,
        output pmod_data, pmod_clk, pmod_latch, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/gamepad_pmod_serializer.sv
// ============================================================================
// gamepad_pmod_serializer
// Shifts a snapshot of 1 or 2 pads' buttons out MSB first, then pulses latch.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gamepad_pmod_serializer #(
    parameter int NUM_PADS   = 1,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16,
    parameter bit AUTO       = 1'b0
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    gamepad_pmod_serializer_if.slave   bus
);
    localparam int BIT_WIDTH = 12 * NUM_PADS;
    localparam int DIV_W     = $clog2(CLK_DIV + 1);
    localparam int BIT_W     = $clog2(BIT_WIDTH);
    localparam int GAP_W     = $clog2(GAP_CYCLES + 1);

    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(BIT_WIDTH - 1);
    localparam logic [GAP_W-1:0] c_gap_last = GAP_W'(GAP_CYCLES - 1);

    if (NUM_PADS != 1 && NUM_PADS != 2) begin : g_bad_num_pads
        $error("NUM_PADS must be 1 or 2");
    end
    if (CLK_DIV < 3) begin : g_bad_clk_div
        $error("CLK_DIV must be at least 3");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("GAP_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOW   = 3'd1,
        HIGH  = 3'd2,
        LATCH = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t               r_state;
    logic [BIT_WIDTH-1:0] r_shreg;
    logic [DIV_W-1:0]     r_div;
    logic [BIT_W-1:0]     r_bit;
    logic [GAP_W-1:0]     r_gap;
    logic                 r_data;
    logic                 r_pclk;
    logic                 r_latch;
    logic                 r_busy;
    logic                 r_done;
    logic [BIT_WIDTH-1:0] w_snapshot;

    // Absent pads read as all-released, which the receiver treats as unplugged.
    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        assign w_snapshot[12*i +: 12] = bus.present[i] ? bus.buttons[12*i +: 12] : 12'hFFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_gap   <= '0;
            r_data  <= 1'b0;
            r_pclk  <= 1'b0;
            r_latch <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (AUTO || bus.start) begin
                        r_shreg <= w_snapshot;
                        r_bit   <= c_bit_last;
                        r_div   <= '0;
                        r_data  <= w_snapshot[BIT_WIDTH-1];
                        r_busy  <= 1'b1;
                        r_state <= LOW;
                    end
                end
                LOW: begin
                    if (r_div == c_div_last) begin
                        r_div   <= '0;
                        r_pclk  <= 1'b1;
                        r_state <= HIGH;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                HIGH: begin
                    if (r_div == c_div_last) begin
                        r_div  <= '0;
                        r_pclk <= 1'b0;
                        if (r_bit == '0) begin
                            r_data  <= 1'b0;
                            r_latch <= 1'b1;
                            r_state <= LATCH;
                        end else begin
                            // Next bit is presented together with the falling clock edge.
                            r_shreg <= r_shreg << 1;
                            r_data  <= r_shreg[BIT_WIDTH-2];
                            r_bit   <= r_bit - 1'b1;
                            r_state <= LOW;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                LATCH: begin
                    if (r_div == c_div_last) begin
                        r_div   <= '0;
                        r_latch <= 1'b0;
                        r_done  <= 1'b1;
                        r_gap   <= '0;
                        r_state <= GAP;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                GAP: begin
                    if (r_gap == c_gap_last) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.pmod_data  = r_data;
    assign bus.pmod_clk   = r_pclk;
    assign bus.pmod_latch = r_latch;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule

`default_nettype wire
